gyro_yaw_reader: RTL and testbench
==================================

Name: gyro_yaw_reader

Overview:
- Producer side of the yaw-rate/valid interface consumed by the heading integrator.
- Initializes the gyro over an external SPI transceiver handshake, waits for the gyro data-ready interrupt, then reads the yaw-rate low and high bytes.
- Presents a signed 16-bit yaw_rt with a one-cycle vld pulse.
- Sits between the SPI transceiver and the integrator; owns all gyro command sequencing.

Parameters:
- FAST_SIM, 1, when 1 the power-up wait timer is 9 bits (512 cycles); when 0 it is 16 bits (65536 cycles).
- TMO_CYC, 24'd1_000_000, INT watchdog limit in clocks; only used with TMO_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- INT  input  1  gyro data-ready interrupt, asynchronous; double-flopped internally
- done  input  1  SPI transceiver: one-cycle pulse, transaction complete
- resp  input  16  SPI transceiver: read data; low byte valid when done is high
- wrt  output  1  SPI transceiver: one-cycle pulse that starts a transaction
- cmd  output  16  SPI transceiver: command word; held stable from wrt until done
- vld  output  1  one-cycle pulse when yaw_rt is updated
- yaw_rt  output  16  signed yaw rate, {high byte, low byte}
- tmo_err  output  1  sticky watchdog flag (TMO_EN only; tied 0 otherwise)

Behaviour:
- Reset: wrt=0, cmd=16'h0000, vld=0, yaw_rt=16'h0000, tmo_err=0, timer=0, INT synchronizer=0, state=INIT_WAIT. Reset is honored mid-transaction; any pending done after reset is ignored because the FSM is in INIT_WAIT.
- INT synchronizer: two flops, INT_ff1 then INT_ff2. Read decisions use INT_ff2 only.
- Timer: increments every cycle in INIT_WAIT. Width is 9 or 16 bits per FAST_SIM. Leaves INIT_WAIT when the timer is all ones.
- States and transitions:
  - INIT_WAIT: when timer is all ones, pulse wrt with cmd=16'h0D02 (INT1 on gyro data-ready) and go to INIT1.
  - INIT1: on done, pulse wrt with cmd=16'h1160 (gyro ODR/range) and go to INIT2.
  - INIT2: on done, pulse wrt with cmd=16'h1440 (rounding enable) and go to INIT3.
  - INIT3: on done, go to IDLE.
  - IDLE: when INT_ff2=1, pulse wrt with cmd=16'hA6xx (read yaw low; xx=00) and go to RD_L.
  - RD_L: on done, capture low_byte<=resp[7:0], pulse wrt with cmd=16'hA700, and go to RD_H.
  - RD_H: on done, set yaw_rt<={resp[7:0], low_byte} and vld<=1 on the same edge, then go to IDLE.
- Timing of wrt and cmd: wrt is registered and asserted on the clock edge that enters the next state. cmd is registered on that same edge and held until the next wrt.
- Latency: vld rises 1 cycle after the done that ends the high-byte read. yaw_rt changes only on that edge and holds between samples.
- done outside INIT1/INIT2/INIT3/RD_L/RD_H is ignored. wrt is never asserted while a transaction is outstanding.
- INT still high when the FSM returns to IDLE: a new read starts immediately. Back-to-back samples are allowed, with 1 idle cycle minimum between vld pulses.
- INT deasserting mid-read: the read completes normally.
- No arithmetic on the data path. yaw_rt is a raw two's-complement concatenation.

Optional Feature:
- Macro TMO_EN.
- When defined:
  - A 24-bit watchdog counts while in IDLE with INT_ff2=0 and clears on leaving IDLE.
  - When it reaches TMO_CYC-1, tmo_err is set (sticky until rst), and the FSM returns to INIT_WAIT with timer=0 so the gyro is re-initialized.
  - vld is not pulsed on a timeout.
- When undefined: no watchdog logic, tmo_err is constant 0, and IDLE waits indefinitely.

Test Plan:
- Power-up (FAST_SIM=1): release rst, INT=0, SPI model returns done 32 cycles after each wrt.
  - Expect the first wrt exactly 512 cycles after reset release.
  - Expect cmd sequence 0D02, 1160, 1440.
  - Expect no further wrt while INT=0.
- Single read: after init, raise INT, model returns low=8'h34 and high=8'h12.
  - Expect cmd A600 then A700.
  - Expect vld high for exactly 1 cycle, one cycle after the second done.
  - Expect yaw_rt=16'h1234.
- Negative value: low=8'h00, high=8'hFC.
  - Expect yaw_rt=16'hFC00 (-1024).
  - Expect yaw_rt unchanged until the next vld.
- INT held high: 3 consecutive samples.
  - Expect 3 vld pulses, 6 wrts in strict A6/A7 alternation, and no wrt issued before the preceding done.
- Reset mid-read: assert rst while in RD_H, and have the model deliver done after reset release.
  - Expect all outputs at reset values, the stray done ignored, and the full init sequence re-run.
- TMO_EN with TMO_CYC=1000: after init, hold INT=0.
  - Expect tmo_err=1 at IDLE+1000 cycles, then re-init, with cmd 0D02 issued 512 cycles later.

Source files
------------

// File: rtl/gyro_yaw_reader.sv
// Gyro yaw-rate reader: initializes the gyro over an SPI transceiver handshake, then reads yaw low/high bytes on each data-ready INT.
// Optional watchdog on a missing INT is enabled by defining TMO_EN.
module gyro_yaw_reader #(
    parameter int          FAST_SIM = 1,
    parameter logic [23:0] TMO_CYC  = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] resp,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic        vld,
    output logic [15:0] yaw_rt,
    output logic        tmo_err
);
    localparam int TMR_W = (FAST_SIM != 0) ? 9 : 16;

    typedef enum logic [2:0] {
        INIT_WAIT,
        INIT1,
        INIT2,
        INIT3,
        IDLE,
        RD_L,
        RD_H
    } state_t;

    state_t             state_reg, state_next;
    logic               int_ff1_reg, int_ff2_reg;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic [7:0]         low_byte_reg, low_byte_next;
    logic               wrt_reg, wrt_next;
    logic [15:0]        cmd_reg, cmd_next;
    logic               vld_reg, vld_next;
    logic [15:0]        yaw_reg, yaw_next;
    logic               wdog_hit;

    // Only the low byte of a transceiver response carries gyro data.
    logic cfg_unused;
    assign cfg_unused = ^{resp[15:8], TMO_CYC};

`ifdef TMO_EN
    logic [23:0] wdog_reg, wdog_next;
    logic        tmo_err_reg, tmo_err_next;

    assign wdog_hit = (state_reg == IDLE) && !int_ff2_reg && (wdog_reg == TMO_CYC - 24'd1);

    always_comb begin
        wdog_next    = 24'd0;
        tmo_err_next = tmo_err_reg | wdog_hit;
        if ((state_reg == IDLE) && !int_ff2_reg && !wdog_hit)
            wdog_next = wdog_reg + 24'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_reg    <= 24'd0;
            tmo_err_reg <= 1'b0;
        end else begin
            wdog_reg    <= wdog_next;
            tmo_err_reg <= tmo_err_next;
        end
    end

    assign tmo_err = tmo_err_reg;
`else
    assign wdog_hit = 1'b0;
    assign tmo_err  = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        wrt_next      = 1'b0;
        cmd_next      = cmd_reg;
        vld_next      = 1'b0;
        yaw_next      = yaw_reg;
        low_byte_next = low_byte_reg;
        timer_next    = (state_reg == INIT_WAIT) ? timer_reg + TMR_W'(1) : '0;

        case (state_reg)
            INIT_WAIT: begin
                if (&timer_reg) begin
                    wrt_next   = 1'b1;
                    cmd_next   = 16'h0D02;
                    state_next = INIT1;
                end
            end
            INIT1: begin
                if (done) begin
                    wrt_next   = 1'b1;
                    cmd_next   = 16'h1160;
                    state_next = INIT2;
                end
            end
            INIT2: begin
                if (done) begin
                    wrt_next   = 1'b1;
                    cmd_next   = 16'h1440;
                    state_next = INIT3;
                end
            end
            INIT3: begin
                if (done)
                    state_next = IDLE;
            end
            IDLE: begin
                // A pending sample wins over a watchdog expiring on the same cycle.
                if (int_ff2_reg) begin
                    wrt_next   = 1'b1;
                    cmd_next   = 16'hA600;
                    state_next = RD_L;
                end else if (wdog_hit) begin
                    state_next = INIT_WAIT;
                end
            end
            RD_L: begin
                if (done) begin
                    low_byte_next = resp[7:0];
                    wrt_next      = 1'b1;
                    cmd_next      = 16'hA700;
                    state_next    = RD_H;
                end
            end
            RD_H: begin
                if (done) begin
                    yaw_next   = {resp[7:0], low_byte_reg};
                    vld_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = INIT_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= INIT_WAIT;
            int_ff1_reg  <= 1'b0;
            int_ff2_reg  <= 1'b0;
            timer_reg    <= '0;
            low_byte_reg <= 8'h00;
            wrt_reg      <= 1'b0;
            cmd_reg      <= 16'h0000;
            vld_reg      <= 1'b0;
            yaw_reg      <= 16'h0000;
        end else begin
            state_reg    <= state_next;
            int_ff1_reg  <= INT;
            int_ff2_reg  <= int_ff1_reg;
            timer_reg    <= timer_next;
            low_byte_reg <= low_byte_next;
            wrt_reg      <= wrt_next;
            cmd_reg      <= cmd_next;
            vld_reg      <= vld_next;
            yaw_reg      <= yaw_next;
        end
    end

    assign wrt    = wrt_reg;
    assign cmd    = cmd_reg;
    assign vld    = vld_reg;
    assign yaw_rt = yaw_reg;

endmodule

// File: tb/tb_gyro_yaw_reader.sv
// Scoreboard bench for gyro_yaw_reader: SPI responder model, expected-command/yaw queues, negedge monitor.
`timescale 1ns/1ps
module tb_gyro_yaw_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        INT = 1'b0;
    logic        done = 1'b0;
    logic [15:0] resp = 16'h0000;
    logic        wrt, vld, tmo_err;
    logic [15:0] cmd, yaw_rt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] exp_cmd_q[$];
    logic [15:0] exp_yaw_q[$];
    logic [7:0]  lo_q[$];
    logic [7:0]  hi_q[$];

    int   n_wrt = 0, n_a6 = 0, n_a7 = 0, n_vld = 0, n_done = 0;
    int   init_ref = 0;
    bit   init_pending = 1'b0;
    int   last_done_edge = 0;
    bit   outstanding = 1'b0, prev_done = 1'b0, prev_vld = 1'b0, prev_tmo = 1'b0;
    logic [15:0] last_yaw = 16'h0000;

    gyro_yaw_reader #(.FAST_SIM(1), .TMO_CYC(24'd1000)) dut (
        .clk(clk), .rst(rst), .INT(INT), .done(done), .resp(resp),
        .wrt(wrt), .cmd(cmd), .vld(vld), .yaw_rt(yaw_rt), .tmo_err(tmo_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic timeout_fail(string nm);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    // Reference model: yaw rate is the high byte weighted by 256 plus the low byte, wrapped to 16 bits.
    function automatic logic [15:0] model_yaw(logic [7:0] lo, logic [7:0] hi);
        int v;
        v = int'(hi) * 256 + int'(lo);
        return 16'(v);
    endfunction

    function automatic int get_cnt(int sel);
        case (sel)
            0: return n_wrt;
            1: return n_a6;
            2: return n_a7;
            3: return n_vld;
            default: return n_done;
        endcase
    endfunction

    task automatic wait_cnt(int sel, int target, int budget, string nm);
        int k = 0;
        while (get_cnt(sel) < target && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        if (get_cnt(sel) < target) timeout_fail(nm);
    endtask

    task automatic chk_reset_vals();
        chk("rst_wrt", wrt, 0);
        chk("rst_cmd", cmd, 16'h0000);
        chk("rst_vld", vld, 0);
        chk("rst_yaw", yaw_rt, 16'h0000);
        chk("rst_tmo", tmo_err, 0);
    endtask

    task automatic push_init();
        exp_cmd_q.push_back(16'h0D02);
        exp_cmd_q.push_back(16'h1160);
        exp_cmd_q.push_back(16'h1440);
    endtask

    task automatic push_sample(logic [7:0] lo, logic [7:0] hi);
        lo_q.push_back(lo);
        hi_q.push_back(hi);
        exp_cmd_q.push_back(16'hA600);
        exp_cmd_q.push_back(16'hA700);
        exp_yaw_q.push_back(model_yaw(lo, hi));
    endtask

    task automatic do_read(logic [7:0] lo, logic [7:0] hi);
        int a6 = n_a6;
        int v  = n_vld;
        push_sample(lo, hi);
        INT = 1'b1;
        wait_cnt(1, a6 + 1, 200, "a6_timeout");
        INT = 1'b0;
        wait_cnt(3, v + 1, 200, "vld_timeout");
        repeat ($urandom_range(2, 20)) @(posedge clk);
        #2;
    endtask

    // SPI transceiver model: done 32 cycles after each wrt, low byte from the sample queues.
    initial begin : spi_model
        logic [15:0] c, r;
        forever begin
            @(posedge clk); #1;
            while (wrt) begin
                c = cmd;
                repeat (31) @(posedge clk);
                #1;
                r = 16'($urandom);
                if (c[15:8] == 8'hA6 && lo_q.size() > 0)
                    r[7:0] = lo_q.pop_front();
                else if (c[15:8] == 8'hA7 && hi_q.size() > 0)
                    r[7:0] = hi_q.pop_front();
                resp = r;
                done = 1'b1;
                @(posedge clk); #1;
                done = 1'b0;
                resp = 16'($urandom);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT issues a command or a sample.
    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (prev_done) outstanding = 1'b0;
            if (rst) last_yaw = 16'h0000;
            if (wrt) begin
                n_wrt++;
                chk("wrt_while_busy", outstanding, 0);
                outstanding = 1'b1;
                if (exp_cmd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_wrt actual=cmd %h required=no wrt", cmd);
                end else begin
                    e = exp_cmd_q.pop_front();
                    chk("cmd", cmd, e);
                end
                if (init_pending) begin
                    chk("init_delay", cyc - init_ref, 512);
                    init_pending = 1'b0;
                end
                if (cmd[15:8] == 8'hA6) n_a6++;
                if (cmd[15:8] == 8'hA7) n_a7++;
            end
            if (vld) begin
                n_vld++;
                chk("vld_after_done", prev_done, 1);
                chk("vld_width", prev_vld, 0);
                if (exp_yaw_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_vld actual=yaw %h required=no vld", yaw_rt);
                end else begin
                    e = exp_yaw_q.pop_front();
                    chk("yaw_rt", yaw_rt, e);
                end
                last_yaw = yaw_rt;
            end else begin
                chk("yaw_hold", yaw_rt, last_yaw);
            end
            if (tmo_err && !prev_tmo) begin
                chk("tmo_delay", cyc - last_done_edge, 1000);
                init_ref     = cyc;
                init_pending = 1'b1;
            end
            if (done) begin
                n_done++;
                last_done_edge = cyc + 1;
            end
            prev_done = done;
            prev_vld  = vld;
            prev_tmo  = tmo_err;
        end
    end

    initial begin : stimulus
        int w, a6, a7, v;
        logic [7:0] lo, hi;

        // Power-up
        repeat (3) @(posedge clk);
        #2;
        chk_reset_vals();
        push_init();
        init_ref     = cyc;
        init_pending = 1'b1;
        rst = 1'b0;
        wait_cnt(0, 1, 700, "first_wrt_timeout");
        wait_cnt(0, 3, 200, "init_timeout");
        repeat (140) @(posedge clk);
        #2;
        chk("no_extra_wrt", n_wrt, 3);

        // Single reads, INT dropped once the read starts
        do_read(8'h34, 8'h12);
        do_read(8'h00, 8'hFC);
        do_read(8'hFF, 8'h7F);
        do_read(8'h00, 8'h80);
        for (int i = 0; i < 4; i++) begin
            lo = 8'($urandom);
            hi = 8'($urandom);
            do_read(lo, hi);
        end

        // INT held high across three samples
        a6 = n_a6;
        v  = n_vld;
        for (int i = 0; i < 3; i++) begin
            lo = 8'($urandom);
            hi = 8'($urandom);
            push_sample(lo, hi);
        end
        INT = 1'b1;
        wait_cnt(1, a6 + 3, 400, "burst_a6_timeout");
        INT = 1'b0;
        wait_cnt(3, v + 3, 200, "burst_vld_timeout");
        chk("burst_vld_count", n_vld - v, 3);
        repeat (10) @(posedge clk);
        #2;

        // Reset while in RD_H; the transceiver's done arrives after release
        a6 = n_a6;
        a7 = n_a7;
        push_sample(8'h5A, 8'hA5);
        INT = 1'b1;
        wait_cnt(1, a6 + 1, 200, "rr_a6_timeout");
        INT = 1'b0;
        wait_cnt(2, a7 + 1, 200, "rr_a7_timeout");
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        exp_cmd_q.delete();
        exp_yaw_q.delete();
        @(posedge clk);
        #2;
        chk_reset_vals();
        @(posedge clk);
        #2;
        w = n_wrt;
        v = n_vld;
        push_init();
        init_ref     = cyc;
        init_pending = 1'b1;
        rst = 1'b0;
        wait_cnt(0, w + 3, 800, "reinit_timeout");
        repeat (40) @(posedge clk);
        #2;
        chk("rr_no_vld", n_vld, v);
        chk("rr_wrt_count", n_wrt - w, 3);

        do_read(8'h78, 8'h56);

`ifdef TMO_EN
        // Watchdog: INT held low until timeout, then full re-init
        push_init();
        begin
            int k = 0;
            while (!tmo_err && k < 2000) begin
                @(posedge clk); #2;
                k++;
            end
            if (!tmo_err) timeout_fail("tmo_timeout");
        end
        w = n_wrt;
        wait_cnt(0, w + 3, 800, "tmo_reinit_timeout");
        repeat (40) @(posedge clk);
        #2;
        chk("tmo_sticky", tmo_err, 1);
`else
        chk("tmo_err_tied", tmo_err, 0);
`endif

        chk("cmd_q_empty", exp_cmd_q.size(), 0);
        chk("yaw_q_empty", exp_yaw_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
